// File: rtl/sd_read_sequencer.sv
// ----------------------------------------------------------------------------
// sd_read_sequencer
//
// Sequences an SD card block read (CMD17 single / CMD18 multiple) into memory:
// latches a request, loads the DMA engine, arms the data path and DMA, issues
// the read command, waits for the transfer to drain, closes multi-block reads
// with CMD12, and reports a result code.
//
// Optional build macro: SD_READ_SEQ_RETRY_EN
//   Defined   : a CMD17/CMD18 timeout or CRC failure restarts from LOAD, up to
//               two retries (three attempts in total).
//   Undefined : the first command failure ends the request.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_start                     request pulse (ignored while busy)
//   i_sector, i_count, i_wide   block address, block count, 4-bit bus select
//   i_bank, i_address           DMA destination
//   o_busy, o_done, o_error     status, one-cycle completion pulse, result
//   o_command_*, i_command_*    command engine interface
//   o_dat_*, i_dat_*            data engine interface, o_rx_fifo_flush
//   o_dma_*, i_dma_busy         DMA engine interface
//   o_dbg_state                 current FSM state, for observation
//
// Handshake: every o_*_start / o_*_stop / o_*_load_* / o_done output is a
// single-cycle strobe; the engines report progress only through their busy
// levels, and their error flags are meaningful once busy has dropped.
//
// Result codes: 0 ok, 1 command timeout, 2 command CRC, 3 data CRC,
// 4 stop-command failure.
// ----------------------------------------------------------------------------
module sd_read_sequencer #(
    parameter logic [6:0] DAT_BLOCK_SIZE = 7'd127
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_sector,
    input  logic [10:0] i_count,
    input  logic        i_wide,
    input  logic [3:0]  i_bank,
    input  logic [23:0] i_address,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_error,
    output logic [5:0]  o_command_index,
    output logic [31:0] o_command_argument,
    output logic        o_command_long_response,
    output logic        o_command_skip_response,
    output logic        o_command_start,
    input  logic        i_command_busy,
    input  logic        i_command_timeout,
    input  logic        i_command_response_crc_error,
    output logic        o_dat_width,
    output logic        o_dat_direction,
    output logic [6:0]  o_dat_block_size,
    output logic [10:0] o_dat_num_blocks,
    output logic        o_dat_start,
    output logic        o_dat_stop,
    input  logic        i_dat_busy,
    input  logic        i_dat_crc_error,
    output logic        o_rx_fifo_flush,
    output logic [3:0]  o_dma_bank,
    output logic [23:0] o_dma_address,
    output logic [17:0] o_dma_length,
    output logic        o_dma_load_bank_address,
    output logic        o_dma_load_length,
    output logic        o_dma_direction,
    output logic        o_dma_start,
    output logic        o_dma_stop,
    input  logic        i_dma_busy,
    output logic [3:0]  o_dbg_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        ARM       = 4'd2,
        CMD       = 4'd3,
        CMD_WAIT  = 4'd4,
        XFER      = 4'd5,
        STOP      = 4'd6,
        STOP_WAIT = 4'd7,
        FINISH    = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_busy;
    logic [2:0]  r_error;
    logic [31:0] r_sector;
    logic [10:0] r_count;
    logic        r_wide;
    logic [3:0]  r_bank;
    logic [23:0] r_address;
    // High in the first cycle of a response wait, when the command engine may
    // not yet have raised its busy flag.
    logic        r_wait_first;

    logic        w_accept;
    logic        w_err_we;
    logic [2:0]  w_err_val;
    logic        w_retry_inc;
    logic        w_can_retry;
    logic        w_single;

`ifdef SD_READ_SEQ_RETRY_EN
    logic [1:0]  r_retry;
    assign w_can_retry = (r_retry != 2'd2);
`else
    assign w_can_retry = 1'b0;
`endif

    assign w_single = (r_count == 11'd1);

    // Static / latched outputs
    assign o_busy                  = r_busy;
    assign o_error                 = r_error;
    assign o_dbg_state             = r_state;
    assign o_dat_block_size        = DAT_BLOCK_SIZE;
    assign o_dat_direction         = 1'b0;
    assign o_dma_direction         = 1'b0;
    assign o_command_long_response = 1'b0;
    assign o_command_skip_response = 1'b0;
    assign o_dat_width             = r_wide;
    assign o_dma_bank              = r_bank;
    assign o_dma_address           = r_address;
    assign o_dat_num_blocks        = (r_count == 11'd0) ? 11'd0 : (r_count - 11'd1);
    // 2047 * 128 = 262016 still fits in 18 bits.
    assign o_dma_length            = 18'(r_count) * (18'(DAT_BLOCK_SIZE) + 18'd1);

    // State register and request latches
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_error      <= 3'd0;
            r_sector     <= 32'd0;
            r_count      <= 11'd0;
            r_wide       <= 1'b0;
            r_bank       <= 4'd0;
            r_address    <= 24'd0;
            r_wait_first <= 1'b0;
`ifdef SD_READ_SEQ_RETRY_EN
            r_retry      <= 2'd0;
`endif
        end else begin
            r_state      <= w_next;
            r_wait_first <= ((w_next == CMD_WAIT) || (w_next == STOP_WAIT)) && (w_next != r_state);
            if (r_state == FINISH) begin
                r_busy <= 1'b0;
            end
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_error   <= 3'd0;
                r_sector  <= i_sector;
                r_count   <= i_count;
                r_wide    <= i_wide;
                r_bank    <= i_bank;
                r_address <= i_address;
`ifdef SD_READ_SEQ_RETRY_EN
                r_retry   <= 2'd0;
`endif
            end
            if (w_err_we) begin
                r_error <= w_err_val;
            end
`ifdef SD_READ_SEQ_RETRY_EN
            if (w_retry_inc) begin
                r_retry <= r_retry + 2'd1;
            end
`endif
        end
    end

    // Next state and strobes. Everything is held low while reset is asserted so
    // an interrupted operation cannot emit a stop pulse on its way out.
    always_comb begin
        w_next                  = r_state;
        w_accept                = 1'b0;
        w_err_we                = 1'b0;
        w_err_val               = r_error;
        w_retry_inc             = 1'b0;
        o_done                  = 1'b0;
        o_command_start         = 1'b0;
        o_command_index         = 6'd0;
        o_command_argument      = 32'd0;
        o_dat_start             = 1'b0;
        o_dat_stop              = 1'b0;
        o_rx_fifo_flush         = 1'b0;
        o_dma_load_bank_address = 1'b0;
        o_dma_load_length       = 1'b0;
        o_dma_start             = 1'b0;
        o_dma_stop              = 1'b0;
        if (!i_reset) begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_accept = 1'b1;
                        w_next   = (i_count == 11'd0) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    o_rx_fifo_flush         = 1'b1;
                    o_dma_load_bank_address = 1'b1;
                    o_dma_load_length       = 1'b1;
                    w_next                  = ARM;
                end
                ARM: begin
                    o_dat_start = 1'b1;
                    o_dma_start = 1'b1;
                    w_next      = CMD;
                end
                CMD: begin
                    o_command_start    = 1'b1;
                    o_command_index    = w_single ? 6'd17 : 6'd18;
                    o_command_argument = r_sector;
                    w_next             = CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (!r_wait_first && !i_command_busy) begin
                        if (i_command_timeout || i_command_response_crc_error) begin
                            if (w_can_retry) begin
                                w_retry_inc = 1'b1;
                                w_next      = LOAD;
                            end else begin
                                w_err_we   = 1'b1;
                                w_err_val  = i_command_timeout ? 3'd1 : 3'd2;
                                o_dat_stop = 1'b1;
                                o_dma_stop = 1'b1;
                                w_next     = FINISH;
                            end
                        end else begin
                            w_next = XFER;
                        end
                    end
                end
                XFER: begin
                    if (!i_dat_busy && !i_dma_busy) begin
                        if (i_dat_crc_error) begin
                            w_err_we  = 1'b1;
                            w_err_val = 3'd3;
                        end
                        if (w_single) begin
                            o_dat_stop = i_dat_crc_error;
                            o_dma_stop = i_dat_crc_error;
                            w_next     = FINISH;
                        end else begin
                            // Multi-block reads always close with CMD12; a data
                            // CRC error is reported after it.
                            w_next = STOP;
                        end
                    end
                end
                STOP: begin
                    o_command_start = 1'b1;
                    o_command_index = 6'd12;
                    w_next          = STOP_WAIT;
                end
                STOP_WAIT: begin
                    if (!r_wait_first && !i_command_busy) begin
                        if ((i_command_timeout || i_command_response_crc_error) && (r_error == 3'd0)) begin
                            w_err_we  = 1'b1;
                            w_err_val = 3'd4;
                        end
                        if (i_command_timeout || i_command_response_crc_error || (r_error != 3'd0)) begin
                            o_dat_stop = 1'b1;
                            o_dma_stop = 1'b1;
                        end
                        w_next = FINISH;
                    end
                end
                FINISH: begin
                    o_done = 1'b1;
                    w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_read_sequencer.md
SD_READ_SEQUENCER -- requirements
Module: sd_read_sequencer

Interface
REQ-001 SHALL have parameter DAT_BLOCK_SIZE, default 7'd127, meaning 32-bit words per block minus one (128 words, 512 bytes).
REQ-002 SHALL have ports i_clk in 1 (sole clock), i_reset in 1 (synchronous, active-high reset).
REQ-003 SHALL have i_start in 1 (request pulse), i_sector in 32 (SDHC block address), i_count in 11 (blocks, 0..2047), i_wide in 1 (1 = 4-bit bus).
REQ-004 SHALL have i_bank in 4, i_address in 24 (DMA destination), o_busy out 1, o_done out 1 (one-cycle pulse), o_error out 3 (result code).
REQ-005 SHALL have command ports o_command_index out 6, o_command_argument out 32, o_command_long_response out 1, o_command_skip_response out 1, o_command_start out 1, i_command_busy in 1, i_command_timeout in 1, i_command_response_crc_error in 1.
REQ-006 SHALL have data ports o_dat_width out 1, o_dat_direction out 1, o_dat_block_size out 7, o_dat_num_blocks out 11, o_dat_start out 1, o_dat_stop out 1, i_dat_busy in 1, i_dat_crc_error in 1, o_rx_fifo_flush out 1.
REQ-007 SHALL have DMA ports o_dma_bank out 4, o_dma_address out 24, o_dma_length out 18, o_dma_load_bank_address out 1, o_dma_load_length out 1, o_dma_direction out 1, o_dma_start out 1, o_dma_stop out 1, i_dma_busy in 1.

Function
REQ-008 States SHALL be IDLE, LOAD, ARM, CMD, CMD_WAIT, XFER, STOP, STOP_WAIT, FINISH.
REQ-009 IDLE: i_start latches all request inputs, sets o_busy next cycle, goes to LOAD; i_start while o_busy SHALL be ignored.
REQ-010 i_count == 0: SHALL go IDLE -> FINISH, o_error 0, no pulse on any command/data/DMA strobe.
REQ-011 LOAD (1 cycle): pulse o_rx_fifo_flush, o_dma_load_bank_address, o_dma_load_length; o_dma_length = count * (DAT_BLOCK_SIZE+1), 18-bit, no overflow for count <= 2047.
REQ-012 ARM (1 cycle): pulse o_dat_start and o_dma_start; o_dat_direction = 0, o_dma_direction = 0 (card to memory), o_dat_width = latched i_wide, o_dat_num_blocks = count - 1.
REQ-013 CMD (1 cycle): pulse o_command_start; index 17 if count == 1, else 18; argument = latched sector; long_response 0, skip_response 0.
REQ-014 CMD_WAIT: ignore i_command_busy in the first cycle, then on i_command_busy low: timeout -> error 1, CRC error -> error 2, else XFER.
REQ-015 XFER: wait until i_dat_busy and i_dma_busy are both low; i_dat_crc_error high at that point -> error 3; count == 1 -> FINISH, else STOP.
REQ-016 STOP (1 cycle): pulse o_command_start with index 12, argument 0; STOP_WAIT as CMD_WAIT; any failure -> error 4, else FINISH.
REQ-017 Any error SHALL pulse o_dat_stop and o_dma_stop together for one cycle, then go to FINISH; error 3 on a multi-block read SHALL still issue CMD12 first, keeping error 3.
REQ-018 FINISH (1 cycle): pulse o_done, clear o_busy, return to IDLE; o_error holds until the next accepted i_start.
REQ-019 Error codes: 0 ok, 1 command timeout, 2 command CRC, 3 data CRC, 4 stop-command failure.
REQ-020 All strobes SHALL be exactly one cycle wide and never overlap, except the o_dat_stop/o_dma_stop pair and the three LOAD pulses.

Reset
REQ-021 i_reset SHALL force IDLE; clear all outputs, latched fields, and the retry counter to 0; emit no stop pulses, even mid-operation.
REQ-022 o_dat_block_size SHALL be DAT_BLOCK_SIZE constantly, including during reset.

Configuration
REQ-023 With SD_READ_SEQ_RETRY_EN defined: a CMD17/18 timeout or CRC error returns to LOAD, up to 2 retries (3 attempts); o_error reflects the last attempt.
REQ-024 Without SD_READ_SEQ_RETRY_EN: the first command failure is terminal and there is no retry counter.

Verification
REQ-025 count=1, sector 0x1234, clean responses -> CMD17 arg 0x00001234, dma_length 128, no CMD12, o_done with error 0.
REQ-026 count=8, i_wide=1 -> CMD18, dat_num_blocks 7, dma_length 1024, CMD12 after both busies drop, error 0.
REQ-027 count=4, i_dat_crc_error at end of transfer -> CMD12 still issued, error 3.
REQ-028 CMD18 timeout on every attempt -> retry build: 3 CMD18 pulses then error 1; non-retry build: 1 pulse then error 1; stop pair pulsed once.
REQ-029 i_reset during XFER, then count=0 request -> all outputs 0, no stop pulses; next request gives o_done within 3 cycles, error 0.
